// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one shared digit cell processes one
// digit per clock, LSD first, framed by a start/busy/done handshake.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  op_sub_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   result_o,
  output logic                  cout_o,
  output logic                  invalid_o
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             op_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic [W-1:0]     dig_q;
  logic             inv_q;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     result_q;
  logic             cout_q;
  logic             invalid_q;

  logic [3:0]       a_dig_s;
  logic [3:0]       b_raw_s;
  logic [3:0]       b_eff_s;
  logic [4:0]       sum_s;
  logic [4:0]       adj_s;
  logic [3:0]       digit_s;
  logic             carry_d;
  logic [W-1:0]     dig_d;
  logic             last_s;

  // True when any 4-bit group of the operand is not a decimal digit.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Shared digit cell: nine's complement of b for subtraction, decimal adjust.
  always_comb begin
    a_dig_s = a_q[4*int'(idx_q) +: 4];
    b_raw_s = b_q[4*int'(idx_q) +: 4];
    b_eff_s = op_q ? (4'd9 - b_raw_s) : b_raw_s;
    sum_s   = {1'b0, a_dig_s} + {1'b0, b_eff_s} + {4'b0000, carry_q};
    adj_s   = 5'd0;
    if (sum_s > 5'd9) begin
      adj_s   = sum_s - 5'd10;
      digit_s = adj_s[3:0];
      carry_d = 1'b1;
    end else begin
      digit_s = sum_s[3:0];
      carry_d = 1'b0;
    end
    dig_d = dig_q;
    dig_d[4*int'(idx_q) +: 4] = digit_s;
    last_s = (idx_q == IDXW'(DIGITS - 1));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      dig_q     <= '0;
      inv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            op_q    <= op_sub_i;
            carry_q <= op_sub_i;
            idx_q   <= '0;
            dig_q   <= '0;
            inv_q   <= has_bad_digit(a_i) | has_bad_digit(b_i);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          dig_q   <= dig_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDXW'(1);
          if (last_s) begin
            // Last digit lands directly in the output registers on entry to DONE.
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= inv_q ? '0 : dig_d;
            cout_q    <= inv_q ? 1'b0 : carry_d;
            invalid_q <= inv_q;
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign cout_o    = cout_q;
  assign invalid_o = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: 4-digit directed table with hand-computed results,
// 1- and 8-digit instances checked against an integer decimal model.
module tb_bcd_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [15:0] a4, b4;
  logic [3:0]  a1, b1;
  logic [31:0] a8, b8;

  logic        busy4, done4, cout4, inv4;
  logic [15:0] res4;
  logic        busy1, done1, cout1, inv1;
  logic [3:0]  res1;
  logic        busy8, done8, cout8, inv8;
  logic [31:0] res8;

  int errors = 0;
  int checks = 0;

  bcd_serial_addsub #(.DIGITS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_sub_i(op_sub), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .result_o(res4), .cout_o(cout4), .invalid_o(inv4));
  bcd_serial_addsub #(.DIGITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_sub_i(op_sub), .a_i(a1), .b_i(b1),
    .busy_o(busy1), .done_o(done1), .result_o(res1), .cout_o(cout1), .invalid_o(inv1));
  bcd_serial_addsub #(.DIGITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_sub_i(op_sub), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .result_o(res8), .cout_o(cout8), .invalid_o(inv8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] res;
    logic        cout;
    logic        inv;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal reference: BCD -> integer, add/sub mod 10^n, integer -> BCD.
  function automatic void model(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic op, output logic [31:0] r, output logic c,
                                output logic inv);
    longint av, bv, m, s;
    logic [3:0] ad, bd;
    av = 0; bv = 0; m = 1; inv = 1'b0;
    for (int d = n - 1; d >= 0; d--) begin
      ad = a[4*d +: 4];
      bd = b[4*d +: 4];
      if (ad > 4'd9 || bd > 4'd9) inv = 1'b1;
      av = av * 10 + longint'(ad);
      bv = bv * 10 + longint'(bd);
      m  = m * 10;
    end
    if (op) begin
      s = av - bv;
      c = (s >= 0);
      if (s < 0) s = s + m;
    end else begin
      s = av + bv;
      c = (s >= m);
      if (s >= m) s = s - m;
    end
    r = 32'd0;
    for (int d = 0; d < n; d++) begin
      r[4*d +: 4] = 4'(s % 10);
      s = s / 10;
    end
    if (inv) begin
      r = 32'd0;
      c = 1'b0;
    end
  endfunction

  // Starts one operation on all three instances and checks each done pulse.
  task automatic run_op(input vec_t v);
    logic [31:0] r1, r8;
    logic        c1, c8, i1, i8;
    logic [15:0] prev4;
    int lat4, lat1, lat8, np4, np1, np8;
    model(1, {28'd0, v.a[3:0]}, {28'd0, v.b[3:0]}, v.op, r1, c1, i1);
    model(8, {v.a, v.a}, {v.b, v.b}, v.op, r8, c8, i8);
    prev4 = res4;
    a4 = v.a; b4 = v.b; a1 = v.a[3:0]; b1 = v.b[3:0];
    a8 = {v.a, v.a}; b8 = {v.b, v.b}; op_sub = v.op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_busy4"}, {31'd0, busy4}, 32'd1);
    lat4 = -1; lat1 = -1; lat8 = -1; np4 = 0; np1 = 0; np8 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy4 & done4) chk({v.name, "_busy_done4"}, {31'd0, busy4 & done4}, 32'd0);
      if (done4) begin
        np4++;
        if (lat4 < 0) begin
          lat4 = k;
          chk({v.name, "_res4"}, {16'd0, res4}, {16'd0, v.res});
          chk({v.name, "_cout4"}, {31'd0, cout4}, {31'd0, v.cout});
          chk({v.name, "_inv4"}, {31'd0, inv4}, {31'd0, v.inv});
        end
      end else if (lat4 < 0) begin
        chk({v.name, "_run_hold4"}, {16'd0, res4}, {16'd0, prev4});
      end
      if (done1) begin
        np1++;
        if (lat1 < 0) begin
          lat1 = k;
          chk({v.name, "_res1"}, {28'd0, res1}, r1);
          chk({v.name, "_cout_inv1"}, {30'd0, cout1, inv1}, {30'd0, c1, i1});
        end
      end
      if (done8) begin
        np8++;
        if (lat8 < 0) begin
          lat8 = k;
          chk({v.name, "_res8"}, res8, r8);
          chk({v.name, "_cout_inv8"}, {30'd0, cout8, inv8}, {30'd0, c8, i8});
        end
      end
    end
    chk({v.name, "_lat4"}, lat4, 32'd4);
    chk({v.name, "_lat1"}, lat1, 32'd1);
    chk({v.name, "_lat8"}, lat8, 32'd8);
    chk({v.name, "_pulses"}, {np4[7:0], np1[7:0], np8[7:0]}, {8'd1, 8'd1, 8'd1});
    chk({v.name, "_hold4"}, {16'd0, res4}, {16'd0, v.res});
  endtask

  initial begin
    int lat, np;
    int dt[$];

    vecs[0] = '{"add_basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"add_ovf",     16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{"add_chain",   16'h4321, 16'h5679, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{"sub_basic",   16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0};
    vecs[5] = '{"sub_borrow",  16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0};
    vecs[6] = '{"inv_a",       16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{"valid_after", 16'h0500, 16'h0250, 1'b0, 16'h0750, 1'b0, 1'b0};
    vecs[8] = '{"inv_b_sub",   16'h0001, 16'h000B, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{"sub_equal",   16'h9999, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0;
    a4 = '0; b4 = '0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ctl4", {29'd0, busy4, done4, cout4, inv4} & 32'hF, 32'd0);
    chk("reset_res4", {16'd0, res4}, 32'd0);
    chk("reset_ctl18", {26'd0, busy1, done1, inv1, busy8, done8, inv8}, 32'd0);
    chk("reset_res8", res8, 32'd0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Start pulsed while busy with different operands must be ignored.
    a4 = 16'h1234; b4 = 16'h5678; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = -1; np = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done4) begin
        np++;
        if (lat < 0) begin
          lat = k;
          chk("ignore_res4", {16'd0, res4}, 32'h0000_6912);
          chk("ignore_cout4", {31'd0, cout4}, 32'd0);
        end
      end
      if (k == 2) begin
        a4 = 16'h9999; b4 = 16'h0001; op_sub = 1'b1; start = 1'b1;
      end
      if (k == 3) start = 1'b0;
    end
    chk("ignore_lat4", lat, 32'd4);
    chk("ignore_pulses4", np, 32'd1);
    repeat (2) @(negedge clk);

    // Start held high: done every DIGITS+1 cycles with no idle gap.
    a4 = 16'h0011; b4 = 16'h0022; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done4) begin
        dt.push_back(k);
        chk("held_res4", {16'd0, res4}, 32'h0000_0033);
        chk("held_busy4", {31'd0, busy4}, 32'd0);
      end
    end
    start = 1'b0;
    chk("held_pulses4", dt.size(), 32'd3);
    if (dt.size() == 3) begin
      chk("held_first4", dt[0], 32'd4);
      chk("held_gap4a", dt[1] - dt[0], 32'd5);
      chk("held_gap4b", dt[2] - dt[1], 32'd5);
    end
    repeat (12) @(negedge clk);

    // Reset two cycles into an operation: immediate clear, no later done.
    a4 = 16'h1234; b4 = 16'h5678; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ctl4", {28'd0, busy4, done4, cout4, inv4}, 32'd0);
    chk("rst_res4", {16'd0, res4}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done4 | done1 | done8) np++;
    end
    chk("rst_no_done", np, 32'd0);
    chk("rst_res4_after", {16'd0, res4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
